// File: rtl/uart_tx_fifo_drain.sv
// Pops bytes from an 8-bit synchronous FIFO and serialises each one as an 8N1 UART frame,
// LSB first, with a fixed number of clock cycles per bit.
module uart_tx_fifo_drain #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StStart = 3'd2;
  localparam logic [2:0] StData  = 3'd3;
  localparam logic [2:0] StStop  = 3'd4;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PenCnt  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             tx_done_q, tx_done_d;
  logic             bit_end;
  logic [2:0]       next_idx;

  // Gated by rst so no pop can leak out while the block is held in reset.
  assign fifo_rd_en = rst && (state_q == StIdle) && enable && !fifo_empty;
  assign busy       = rst && (state_q != StIdle);
  assign tx         = tx_q;
  assign tx_done    = tx_done_q;
  assign bit_end    = (cnt_q == LastCnt);
  assign next_idx   = bit_idx_q + 3'd1;

  // tx_d is derived from the state being entered so tx lines up with the state's first cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    tx_done_d = 1'b0;
    case (state_q)
      StIdle: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        if (fifo_rd_en) state_d = StLoad;
      end
      StLoad: begin
        shift_d = fifo_data;
        state_d = StStart;
        cnt_d   = '0;
        tx_d    = 1'b0;
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = next_idx;
            tx_d      = shift_q[next_idx];
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StStop: begin
        // Registered pulse: set one cycle early so it lands on the final stop cycle.
        tx_done_d = (cnt_q == PenCnt);
        if (bit_end) begin
          state_d = StIdle;
          cnt_d   = '0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      tx_done_q <= tx_done_d;
    end
  end

endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
- Downstream consumer of the 8-bit synchronous FIFO.
- Pops one byte at a time through the FIFO's rd_en/empty/data_out interface.
- Serialises each byte onto a UART line as 8N1, LSB first, at a fixed clock-cycles-per-bit rate.
- Sits between the FIFO and the board TX pin; used by firmware/test logic to stream bytes out.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per UART bit (12 MHz / 115200); legal range 2..65535.
- CNT_W, 16, width of the baud counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- enable  input  1  1 = allowed to start a new frame; sampled only in IDLE.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  8  FIFO data_out; valid the cycle after a pop.
- fifo_rd_en  output  1  pop request to the FIFO; combinational, one-cycle pulse.
- tx  output  1  serial line, idle high; registered.
- busy  output  1  1 in every state except IDLE; registered or decoded from state.
- tx_done  output  1  one-cycle pulse on the last cycle of the stop bit; registered.

Behaviour:
- Reset (rst=0 at edge): state=IDLE, tx=1, tx_done=0, baud counter=0, bit index=0, shift register=0. busy=0 and fifo_rd_en=0 during reset.
- States: IDLE, LOAD, START, DATA, STOP.
- IDLE: fifo_rd_en = enable && !fifo_empty, combinational. If it is 1, the next state is LOAD; otherwise stay in IDLE. tx=1.
- LOAD (1 cycle): shift register <= fifo_data, which the FIFO registered on the previous edge. Next state is START. fifo_rd_en=0, tx=1.
- START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index=0.
- DATA: tx = shift[bit index] for CLKS_PER_BIT cycles per bit, bits 0..7 in order. After bit 7, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. tx_done=1 on the final cycle of STOP. Next state is IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and resets to 0 on every bit boundary and every state change.
  - Bit index is 3 bits and advances only at a bit boundary in DATA.
- tx is registered: the value for a state appears from the first cycle the FSM is in that state. There are no glitches; tx changes only at bit boundaries.
- Latency: the first start-bit cycle comes 2 cycles after the IDLE cycle that pops.
- Frame length: 10*CLKS_PER_BIT cycles. Back-to-back frame period with the FIFO non-empty: 10*CLKS_PER_BIT + 2 cycles (one IDLE cycle plus one LOAD cycle with tx=1).
- fifo_rd_en is never asserted outside IDLE and never while fifo_empty=1. Exactly one pop per frame; no double pops.
- enable deasserted mid-frame: the current frame completes normally; no new pop afterwards.
- fifo_empty toggling mid-frame: ignored.
- Reset mid-frame: tx=1 on the next edge and the FSM returns to IDLE. The popped byte is discarded and tx_done is not pulsed.
- Reset during LOAD: the byte is discarded; the FIFO is not re-read for it.

Test Plan:
- Run all scenarios with CLKS_PER_BIT=4.
- Reset hold: rst=0 for 3 cycles with fifo_empty=0 -> tx=1, busy=0, fifo_rd_en=0, tx_done=0 throughout.
- Single byte 0xA5 in the FIFO, enable=1:
  - fifo_rd_en high for exactly 1 cycle; start bit begins 2 cycles later.
  - tx sequence, 4 cycles each: 0,1,0,1,0,0,1,0,1,1.
  - tx_done pulses once on the 40th frame cycle; busy then drops.
- Back-to-back 0x00 then 0xFF: the second start bit falls exactly 42 cycles after the first. There are exactly 2 fifo_rd_en pulses, and the FIFO reads empty at the end.
- enable=0 with a non-empty FIFO for 50 cycles -> no fifo_rd_en and tx=1. Raise enable -> pop on the same cycle, frame follows.
- Reset asserted in DATA during bit 3 of 0x3C:
  - tx=1 next cycle, state IDLE, no tx_done.
  - After rst=1, the next FIFO byte (0x81) is transmitted correctly.
- Empty FIFO with enable=1 for 100 cycles -> fifo_rd_en stays 0, tx=1, busy=0.
